// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg: shared arbiter state encoding and counter sizing helper
package mux2_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_OWN0    = 2'b01,
    ARB_OWN1    = 2'b10,
    ARB_ILLEGAL = 2'b11
  } arb_state_e;
  function automatic int cnt_width(input int max_hold);
    return max_hold > 0 ? $clog2(max_hold + 1) : 1;
  endfunction
endpackage

// File: rtl/mux2_arbiter_mux2.sv
// mux2: two-input WIDTH-bit multiplexer, sel=0 picks d0
module mux2 #(
  parameter int WIDTH = 4
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin two-requester arbiter owning the select of a shared mux2
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             done0,
  input  logic             done1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic             busy
);
  localparam int CW = cnt_width(MAX_HOLD);
  arb_state_e state_q, state_d;
  logic last_q, last_d, sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic k, mine_req, other_req, mine_done, preempt;
  assign k         = state_q == ARB_OWN1;
  assign mine_req  = k ? req1 : req0;
  assign other_req = k ? req0 : req1;
  assign mine_done = k ? done1 : done0;
  assign preempt   = (MAX_HOLD != 0) && other_req && cnt_q == CW'(MAX_HOLD - 1);
  // next owner, hold counter, last owner and sticky select
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: if (req0 || req1) state_d = (req0 && (!req1 || last_q)) ? ARB_OWN0 : ARB_OWN1;
      ARB_OWN0, ARB_OWN1:
        if (mine_done || !mine_req || preempt) begin
          last_d  = k;
          cnt_d   = '0;
          state_d = other_req ? (k ? ARB_OWN0 : ARB_OWN1) : ARB_IDLE;
        end else if (other_req && cnt_q != CW'(MAX_HOLD)) cnt_d = cnt_q + CW'(1);
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
    sel_d = state_d == ARB_OWN1 ? 1'b1 : state_d == ARB_OWN0 ? 1'b0 : sel_q;
  end
  // state registers; reset makes requester 0 win the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end
  assign gnt0    = state_q == ARB_OWN0;
  assign gnt1    = state_q == ARB_OWN1;
  assign sel     = sel_q;
  assign y_valid = gnt0 || gnt1;
  assign busy    = state_q != ARB_IDLE;
  mux2 #(.WIDTH(WIDTH)) u_mux (.sel(sel_q), .d0(d0), .d1(d1), .y(y));
endmodule
